wb_port_arbiter: RTL

Writeback-port arbiter sharing the single GPR/FPR write port between the in-order pipeline writeback and the long-latency unit (multiply/divide). Sits between the MEM/WB stage plus long-latency result queue and the register-file write inputs of the decode stage (`reg_we_in`, `Rw_in`, `BUS_W`, `FBUS_W`). The pipeline has priority. A starvation counter forces a one-cycle pipeline stall so a blocked long-latency result can retire.

---
 rtl/wb_port_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the GPR/FPR write port between pipeline writeback and the long-latency unit.
// Define WB_STARVE_EN to add the starvation counter and one-cycle FORCE grant for the long-latency unit.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic        pipe_fp,
    input  logic [0:4]  pipe_rw,
    input  logic [0:31] pipe_data,
    input  logic        lu_valid,
    input  logic        lu_fp,
    input  logic [0:4]  lu_rw,
    input  logic [0:31] lu_data,
    output logic        lu_ready,
    output logic        stall_pipe,
    output logic        reg_we,
    output logic        freg_we,
    output logic [0:4]  Rw,
    output logic [0:31] BUS_W,
    output logic [0:31] FBUS_W
);
    logic        force_grant;
    logic        pipe_win;
    logic        win;
    logic        win_fp;
    logic [0:4]  win_rw;
    logic [0:31] win_data;
`ifdef WB_STARVE_EN
    typedef enum logic {PIPE, FORCE} state_t;
    state_t     state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic       blocked;
    assign force_grant = (state == FORCE);
    assign blocked     = lu_valid && !lu_ready;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= PIPE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end
    // FORCE lasts one cycle and always falls back to PIPE with a cleared counter
    always_comb begin
        state_next    = PIPE;
        wait_cnt_next = '0;
        if (state == PIPE && blocked) begin
            wait_cnt_next = wait_cnt + 4'd1;
            state_next    = (wait_cnt == 4'(STARVE_LIMIT - 1)) ? FORCE : PIPE;
        end
    end
`else
    logic unused_limit;
    assign force_grant  = 1'b0;
    assign unused_limit = ^STARVE_LIMIT;
`endif
    assign stall_pipe = force_grant;
    assign lu_ready   = reset && (force_grant || !pipe_we);
    assign pipe_win   = pipe_we && !force_grant;
    assign win        = pipe_win || (lu_valid && lu_ready);
    assign win_fp     = pipe_win ? pipe_fp : lu_fp;
    assign win_rw     = pipe_win ? pipe_rw : lu_rw;
    assign win_data   = pipe_win ? pipe_data : lu_data;
    // r0 writes are dropped but Rw still tracks the winner; the unused data bus holds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_we  <= 1'b0;
            freg_we <= 1'b0;
            Rw      <= '0;
            BUS_W   <= '0;
            FBUS_W  <= '0;
        end else begin
            reg_we  <= win && !win_fp && (win_rw != 5'd0);
            freg_we <= win && win_fp;
            if (win) Rw <= win_rw;
            if (win && !win_fp) BUS_W <= win_data;
            if (win && win_fp) FBUS_W <= win_data;
        end
    end
endmodule
